// File: rtl/text_console_writer_if.sv
// Character input handshake and frame-buffer memory bus for the text console writer.
// The writer drives the memory side and answers the character handshake.
interface text_console_writer_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [7:0]            char_in;
    logic                  char_valid;
    logic                  char_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wr_en;
    logic [15:0]           mem_wr_data;
    logic [15:0]           mem_rd_data;

    modport master (
        input  char_in,
        input  char_valid,
        output char_ready,
        output mem_addr,
        output mem_wr_en,
        output mem_wr_data,
        input  mem_rd_data
    );

    modport slave (
        output char_in,
        output char_valid,
        input  char_ready,
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/text_console_writer.sv
// 80x60 text console writer: places glyphs into a 16-bit word frame buffer,
// handles CR/LF/BS/FF control codes and clears rows as the cursor scrolls.
module text_console_writer #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] FB_BASE    = ADDR_WIDTH'(16'h3000),
    parameter logic [7:0]            BLANK      = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    text_console_writer_if.master bus,
    output logic [6:0]           cursor_col,
    output logic [5:0]           cursor_row
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        CLR_ROW,
        CLR_ALL
    } state_e;

    localparam logic [7:0]  CH_BS     = 8'h08;
    localparam logic [7:0]  CH_LF     = 8'h0A;
    localparam logic [7:0]  CH_FF     = 8'h0C;
    localparam logic [7:0]  CH_CR     = 8'h0D;
    localparam logic [6:0]  LAST_COL  = 7'd79;
    localparam logic [5:0]  LAST_ROW  = 6'd59;
    localparam logic [11:0] ROW_LAST  = 12'd39;
    localparam logic [11:0] SCR_LAST  = 12'd2399;

    state_e                state_q, state_d;
    logic [6:0]            col_q, col_d;
    logic [5:0]            row_q, row_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_en_q, wr_en_d;
    logic [15:0]           wr_data_q, wr_data_d;
    logic [7:0]            char_q, char_d;
    logic                  bs_q, bs_d;
    logic [11:0]           cnt_q, cnt_d;

    logic                  ready;
    logic                  accept;
    logic [5:0]            next_row;
    logic                  start_clr;
    logic [15:0]           merged;

    function automatic logic [ADDR_WIDTH-1:0] word_addr(
        input logic [5:0] row,
        input logic [6:0] col
    );
        logic [15:0] off;
        off = 16'(row) * 16'd40 + 16'(col[6:1]);
        return FB_BASE + ADDR_WIDTH'(off);
    endfunction

    assign ready    = (state_q == IDLE) && !reset;
    assign accept   = bus.char_valid && ready;
    assign next_row = (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;

    // Read-modify-write merge: even column lives in the high byte.
    assign merged = col_q[0] ? {bus.mem_rd_data[15:8], char_q}
                             : {char_q, bus.mem_rd_data[7:0]};

    // Next-state and next-output computation for the whole writer.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        addr_d    = addr_q;
        wr_en_d   = wr_en_q;
        wr_data_d = wr_data_q;
        char_d    = char_q;
        bs_d      = bs_q;
        cnt_d     = cnt_q;
        start_clr = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        (bus.char_in == CH_CR): begin
                            col_d = 7'd0;
                        end
                        (bus.char_in == CH_LF): begin
                            col_d     = 7'd0;
                            row_d     = next_row;
                            start_clr = 1'b1;
                        end
                        (bus.char_in == CH_FF): begin
                            col_d     = 7'd0;
                            row_d     = 6'd0;
                            state_d   = CLR_ALL;
                            addr_d    = FB_BASE;
                            wr_en_d   = 1'b1;
                            wr_data_d = {BLANK, BLANK};
                            cnt_d     = 12'd0;
                        end
                        (bus.char_in == CH_BS): begin
                            if (col_q != 7'd0) begin
                                col_d   = col_q - 7'd1;
                                char_d  = BLANK;
                                bs_d    = 1'b1;
                                addr_d  = word_addr(row_q, col_q - 7'd1);
                                state_d = READ;
                            end
                        end
                        default: begin
                            char_d  = bus.char_in;
                            bs_d    = 1'b0;
                            addr_d  = word_addr(row_q, col_q);
                            state_d = READ;
                        end
                    endcase
                end
            end
            READ: begin
                state_d = WRITE;
                wr_en_d = 1'b1;
            end
            WRITE: begin
                wr_data_d = merged;
                wr_en_d   = 1'b0;
                state_d   = IDLE;
                if (!bs_q) begin
                    if (col_q < LAST_COL) begin
                        col_d = col_q + 7'd1;
                    end else begin
                        col_d     = 7'd0;
                        row_d     = next_row;
                        start_clr = 1'b1;
                    end
                end
            end
            CLR_ROW, CLR_ALL: begin
                if (cnt_q == ((state_q == CLR_ROW) ? ROW_LAST : SCR_LAST)) begin
                    state_d = IDLE;
                    wr_en_d = 1'b0;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    cnt_d  = cnt_q + 12'd1;
                end
            end
            default: begin
                state_d = IDLE;
                wr_en_d = 1'b0;
            end
        endcase

        // A row clear always starts at column 0 of the row just entered.
        if (start_clr) begin
            state_d   = CLR_ROW;
            addr_d    = word_addr(next_row, 7'd0);
            wr_en_d   = 1'b1;
            wr_data_d = {BLANK, BLANK};
            cnt_d     = 12'd0;
        end
    end

    // State and registered outputs; reset abandons any pending access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            col_q     <= 7'd0;
            row_q     <= 6'd0;
            addr_q    <= FB_BASE;
            wr_en_q   <= 1'b0;
            wr_data_q <= 16'h0000;
            char_q    <= 8'h00;
            bs_q      <= 1'b0;
            cnt_q     <= 12'd0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            char_q    <= char_d;
            bs_q      <= bs_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.char_ready  = ready;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_wr_data = (state_q == WRITE) ? merged : wr_data_q;
    assign cursor_col      = col_q;
    assign cursor_row      = row_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: glyph-grid model with an expected-write
// queue, directed corner cases followed by a randomized character stream.
module tb_text_console_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] cursor_col;
    logic [5:0] cursor_row;

    always #5 clk = ~clk;

    text_console_writer_if #(.ADDR_WIDTH(16)) bus();

    text_console_writer #(
        .ADDR_WIDTH(16),
        .FB_BASE(16'h3000),
        .BLANK(8'h00)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .cursor_col(cursor_col),
        .cursor_row(cursor_row)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    logic [15:0] ram [0:65535];
    byte unsigned g [0:4799];
    int          mc;
    int          mr;
    wr_t         exp_q[$];
    logic [15:0] wr_log[$];
    logic [15:0] wr_dlog[$];
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          cyc = 0;
    int          last_wr_cyc = 0;
    int          acc_cyc = 0;
    bit          skip = 1'b0;

    // Synchronous frame-buffer RAM.
    always @(posedge clk) begin
        if (bus.mem_wr_en === 1'b1) ram[bus.mem_addr] <= bus.mem_wr_data;
        bus.mem_rd_data <= ram[bus.mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic logic [15:0] mword(int r, int w);
        return {g[r*80+2*w], g[r*80+2*w+1]};
    endfunction

    function automatic void push_word(int r, int w);
        wr_t e;
        e.a = 16'h3000 + 16'(r*40 + w);
        e.d = mword(r, w);
        exp_q.push_back(e);
    endfunction

    function automatic void clear_row(int r);
        for (int c = 0; c < 80; c++) g[r*80+c] = 8'h00;
        for (int w = 0; w < 40; w++) push_word(r, w);
    endfunction

    function automatic void advance_row();
        mr = (mr + 1) % 60;
        clear_row(mr);
    endfunction

    // Returns the number of busy cycles the character should cost.
    function automatic int model_char(byte unsigned c);
        int busy;
        busy = 0;
        case (c)
            8'h0D: mc = 0;
            8'h0A: begin
                mc = 0;
                advance_row();
                busy = 40;
            end
            8'h0C: begin
                mc = 0;
                mr = 0;
                for (int i = 0; i < 4800; i++) g[i] = 8'h00;
                for (int r = 0; r < 60; r++)
                    for (int w = 0; w < 40; w++) push_word(r, w);
                busy = 2400;
            end
            8'h08: begin
                if (mc > 0) begin
                    mc--;
                    g[mr*80+mc] = 8'h00;
                    push_word(mr, mc/2);
                    busy = 2;
                end
            end
            default: begin
                g[mr*80+mc] = c;
                push_word(mr, mc/2);
                busy = 2;
                if (mc < 79) mc++;
                else begin
                    mc = 0;
                    advance_row();
                    busy += 40;
                end
            end
        endcase
        return busy;
    endfunction

    function automatic byte unsigned rand_print();
        byte unsigned c;
        do c = 8'($urandom);
        while (c == 8'h08 || c == 8'h0A || c == 8'h0C || c == 8'h0D);
        return c;
    endfunction

    // Write monitor: every strobe must match the next expected write.
    always @(negedge clk) begin
        if (bus.mem_wr_en === 1'b1) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            wr_log.push_back(bus.mem_addr);
            wr_dlog.push_back(bus.mem_wr_data);
            if (!skip) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", int'(bus.mem_addr), -1);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", int'(bus.mem_addr), int'(e.a));
                    check("wr_data", int'(bus.mem_wr_data), int'(e.d));
                end
            end
        end
    end

    task automatic send_char(input byte unsigned c, output int lat);
        int n;
        int busy;
        n = 0;
        while (bus.char_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (bus.char_ready !== 1'b1) begin
            check("ready_timeout", 0, 1);
            lat = -1;
            return;
        end
        busy = model_char(c);
        bus.char_in    = c;
        bus.char_valid = 1'b1;
        @(negedge clk);
        acc_cyc = cyc;
        lat = 1;
        while (bus.char_ready !== 1'b1 && lat < 2600) begin
            bus.char_valid = 1'($urandom_range(0, 1));
            bus.char_in    = 8'($urandom);
            @(negedge clk);
            lat++;
        end
        bus.char_valid = 1'b0;
        check("latency", lat, busy + 1);
        check("cursor_col", int'(cursor_col), mc);
        check("cursor_row", int'(cursor_row), mr);
    endtask

    initial begin
        int lat;
        int r;
        int w0;
        bus.char_in    = 8'h00;
        bus.char_valid = 1'b0;
        mc = 0;
        mr = 0;
        for (int i = 0; i < 2400; i++) begin
            logic [15:0] v;
            v = (i == 0) ? 16'hAABB : 16'($urandom);
            ram[16'h3000 + 16'(i)] = v;
            g[2*i]   = v[15:8];
            g[2*i+1] = v[7:0];
        end

        repeat (3) @(negedge clk);
        check("rst_ready", int'(bus.char_ready), 0);
        check("rst_wr_en", int'(bus.mem_wr_en), 0);
        check("rst_addr", int'(bus.mem_addr), 16'h3000);
        check("rst_wr_data", int'(bus.mem_wr_data), 0);
        check("rst_col", int'(cursor_col), 0);
        check("rst_row", int'(cursor_row), 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", int'(bus.char_ready), 1);

        send_char(8'h41, lat);
        check("A_latency", lat, 3);
        check("A_addr", int'(wr_log[wr_log.size()-1]), 16'h3000);
        check("A_data", int'(wr_dlog[wr_dlog.size()-1]), 16'h41BB);
        check("A_wr_cycle", last_wr_cyc - acc_cyc, 1);
        check("A_col", int'(cursor_col), 1);
        check("A_row", int'(cursor_row), 0);

        send_char(8'h42, lat);
        check("B_data", int'(wr_dlog[wr_dlog.size()-1]), 16'h4142);
        check("B_col", int'(cursor_col), 2);

        send_char(8'h0D, lat);
        check("CR_latency", lat, 1);
        for (int i = 0; i < 59; i++) send_char(8'h0A, lat);
        for (int i = 0; i < 79; i++) send_char(rand_print(), lat);
        check("pos_col", int'(cursor_col), 79);
        check("pos_row", int'(cursor_row), 59);
        wr_log.delete();
        wr_dlog.delete();
        send_char(8'h5A, lat);
        check("wrap_latency", lat, 43);
        check("wrap_nwr", wr_log.size(), 41);
        check("wrap_addr0", int'(wr_log[0]), 16'h395F);
        check("wrap_lo", int'(wr_dlog[0][7:0]), 8'h5A);
        check("wrap_addr_last", int'(wr_log[40]), 16'h3027);
        check("wrap_data_last", int'(wr_dlog[40]), 0);
        check("wrap_col", int'(cursor_col), 0);
        check("wrap_row", int'(cursor_row), 0);

        wr_log.delete();
        wr_dlog.delete();
        send_char(8'h0C, lat);
        check("ff_latency", lat, 2401);
        check("ff_nwr", wr_log.size(), 2400);
        check("ff_first", int'(wr_log[0]), 16'h3000);
        check("ff_last", int'(wr_log[2399]), 16'h395F);

        for (int i = 0; i < 5; i++) send_char(8'h0A, lat);
        wr_log.delete();
        wr_dlog.delete();
        send_char(8'h08, lat);
        check("bs0_latency", lat, 1);
        check("bs0_nwr", wr_log.size(), 0);
        check("bs0_col", int'(cursor_col), 0);
        for (int i = 0; i < 3; i++) send_char(rand_print(), lat);
        wr_log.delete();
        wr_dlog.delete();
        send_char(8'h08, lat);
        check("bs_col", int'(cursor_col), 2);
        check("bs_row", int'(cursor_row), 5);
        check("bs_addr", int'(wr_log[0]), 16'h30C9);
        check("bs_hi", int'(wr_dlog[0][15:8]), 8'h00);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 4) send_char(8'h0D, lat);
            else if (r < 9) send_char(8'h0A, lat);
            else if (r < 16) send_char(8'h08, lat);
            else if (r == 16) send_char(8'h0C, lat);
            else send_char(rand_print(), lat);
        end
        repeat (2) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        for (int i = 0; i < 2400; i++)
            check("fb_word", int'(ram[16'h3000 + 16'(i)]), int'(mword(i/40, i%40)));

        skip = 1'b1;
        w0 = wr_cnt;
        bus.char_in    = 8'h0C;
        bus.char_valid = 1'b1;
        @(negedge clk);
        bus.char_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rstmid_wr_en", int'(bus.mem_wr_en), 0);
        check("rstmid_addr", int'(bus.mem_addr), 16'h3000);
        check("rstmid_wr_data", int'(bus.mem_wr_data), 0);
        check("rstmid_col", int'(cursor_col), 0);
        check("rstmid_row", int'(cursor_row), 0);
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_ready", int'(bus.char_ready), 1);
        repeat (50) @(negedge clk);
        check("rstmid_nwr", wr_cnt - w0, 10);
        check("rstmid_kept", int'(ram[16'h3000 + 16'd100]), int'(mword(2, 20)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
